kws_layer_sched: RTL and testbench
==================================

# kws_layer_sched

Frame-level scheduler for the KWS feature datapath (cmvn → linear → relu). After a start command it drives each enabled stage's enable for exactly one frame of `FRAME_LEN` valid outputs, then advances to the next stage. It repeats the stage sequence for a programmed number of frames and reports completion, abort or a stall timeout. It sits between the Wishbone command decode and the stage enables, and replaces free-running enables from the opcode FSM.

## Interface
Parameters:
- `FRAME_LEN`, 32 — `output_valid` pulses per stage per frame; range 2..256.
- `TIMEOUT`, 255 — maximum cycles between consecutive valids inside a stage before an error is raised.

Ports:
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `start`  in  1  — one-cycle command pulse; ignored while `busy`.
- `abort`  in  1  — cancels the job; takes priority over all other inputs except reset.
- `num_frames`  in  8  — frames to run; sampled on an accepted `start`.
- `stage_mask`  in  3  — bit0 = cmvn, bit1 = linear, bit2 = relu; sampled on an accepted `start`.
- `cmvn_valid`, `linear_valid`, `relu_valid`  in  1 each — per-element valid from each stage.
- `cmvn_en`, `linear_en`, `relu_en`  out  1 each — stage enables.
- `busy`  out  1 — high from the cycle after an accepted `start` until the job ends.
- `done`  out  1 — one-cycle pulse on normal completion.
- `err_timeout`  out  1 — sticky; cleared by the next accepted `start` or by reset.
- `frame_cnt`  out  8 — index of the frame in progress.
- `elem_cnt`  out  8 — valids counted so far in the current stage.
- `state`  out  3 — encoded state, for status readback.

## Operation
- States: IDLE=0, CMVN=1, LIN=2, RELU=3, NEXT=4, DONE=5, ERR=6.
- Enables are a Moore decode of the state register: `cmvn_en` is high only in CMVN, `linear_en` only in LIN, `relu_en` only in RELU.
- IDLE + `start`:
  - Latch `num_frames` and `stage_mask`; clear `frame_cnt`, `elem_cnt` and `err_timeout`.
  - If the mask is 0 or `num_frames` is 0, go to DONE.
  - Otherwise go to the lowest enabled stage.
- Stage state:
  - Only the matching `*_valid` counts; valids from other stages are ignored.
  - On a counted valid with `elem_cnt == FRAME_LEN-1`: clear `elem_cnt` and go to the next higher enabled stage, or to NEXT if none remains.
  - Otherwise a counted valid increments `elem_cnt`.
- NEXT:
  - If `frame_cnt == num_frames-1`, go to DONE.
  - Otherwise increment `frame_cnt` and go to the lowest enabled stage.
- DONE: `done` is high for one cycle, then go to IDLE.
- ERR: set `err_timeout`, then go to IDLE. `done` is not asserted.
- `abort`, in any non-IDLE state: go to IDLE next cycle. All enables drop; no `done`; `err_timeout` is unchanged.
- `busy` is high in every state except IDLE.
- All counters use unsigned arithmetic and never wrap inside a job, because the transitions above bound them.

## Timing
- Reset values: state IDLE; all enables 0; `busy`, `done`, `err_timeout` 0; `frame_cnt` and `elem_cnt` 0.
- `start` at cycle t: the first enable and `busy` are high at t+1.
- Last valid of a non-final stage at t: the next stage's enable is high at t+1 and the previous enable is low at t+1. There is no gap and no overlap.
- Last valid of the final stage at t:
  - NEXT at t+1, with all enables low.
  - At t+2, either the first stage's enable is high again, or `done` = 1.
  - When `done` fires at t+2, `busy` is 0 at t+3.
- Watchdog:
  - The cycle counter resets on entry to each stage and on every counted valid.
  - When it reaches `TIMEOUT`, the next state is ERR; `err_timeout` = 1 one cycle later.
- Simultaneous events:
  - `start` while `busy`: ignored.
  - `abort` together with the final valid: abort wins, no `done`.
  - `abort` in IDLE: no effect.
  - `start` and `abort` in the same IDLE cycle: abort wins, so `start` is dropped.
- Reset mid-job: all outputs return to their reset values on the next clock edge.

## Configuration
- `KWS_SCHED_TIMEOUT_EN` defined: the watchdog counter and the ERR state are implemented as described above.
- `KWS_SCHED_TIMEOUT_EN` not defined:
  - There is no watchdog and ERR is unreachable.
  - `err_timeout` is tied to 0.
  - A stage waits indefinitely for its valids.

## Test plan
All scenarios use `FRAME_LEN` = 4.
- Basic run: `start` with mask=3'b111, `num_frames`=2, each stage returning 4 valids.
  - Response: enable sequence CMVN, LIN, RELU, CMVN, LIN, RELU with no enable overlap.
  - `done` fires 2 cycles after the 24th valid; final `frame_cnt` = 1.
- Sparse mask: mask=3'b101, `num_frames`=1.
  - Response: `linear_en` is never high; `relu_en` rises the cycle after the 4th `cmvn_valid`.
  - Stray `linear_valid` pulses do not change `elem_cnt`.
- Empty job: mask=0, `num_frames`=5.
  - Response: `done` at t+1 after `start`; no enable ever asserted.
- Abort: `abort` in LIN after 2 valids.
  - Response: all enables and `busy` are 0 the next cycle; `done` stays 0.
  - A new `start` then runs normally from `frame_cnt` = 0.
- Timeout (macro defined, `TIMEOUT`=10): withhold `cmvn_valid` after `start`.
  - Response: `err_timeout` = 1 and state IDLE 12 cycles after `start`, with no `done`.
  - The next `start` clears `err_timeout`.
  - With the macro undefined, the same stimulus keeps `cmvn_en` high indefinitely.
- Busy `start` and reset: a second `start` mid-job with mask=3'b010.
  - Response: ignored; the original mask sequence continues.
  - `rst_n`=0 mid-RELU gives every output its reset value at the next edge.

Source files
------------

// File: rtl/kws_layer_sched.sv
// rtl/kws_layer_sched.sv - frame-level stage scheduler for the KWS cmvn/linear/relu datapath
// Optional watchdog and ERR state are built when KWS_SCHED_TIMEOUT_EN is defined.
module kws_layer_sched #(
  parameter int FRAME_LEN = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_frames,
  input  logic [2:0] stage_mask,
  input  logic       cmvn_valid,
  input  logic       linear_valid,
  input  logic       relu_valid,
  output logic       cmvn_en,
  output logic       linear_en,
  output logic       relu_en,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic [7:0] frame_cnt,
  output logic [7:0] elem_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMVN = 3'd1,
    S_LIN  = 3'd2,
    S_RELU = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] ELEM_LAST = 8'(FRAME_LEN - 1);

  state_t     st;
  logic [7:0] nf_q;
  logic [2:0] mask_q;
  logic       cur_valid;
  logic [1:0] lo_next;

  // Lowest enabled stage whose index is >= lo; S_NEXT when none is left.
  function automatic state_t first_from(input logic [2:0] m, input logic [1:0] lo);
    if (m[0] && lo == 2'd0) return S_CMVN;
    if (m[1] && lo <= 2'd1) return S_LIN;
    if (m[2] && lo <= 2'd2) return S_RELU;
    return S_NEXT;
  endfunction

  always_comb begin
    cur_valid = 1'b0;
    lo_next   = 2'd3;
    case (st)
      S_CMVN: begin cur_valid = cmvn_valid;   lo_next = 2'd1; end
      S_LIN:  begin cur_valid = linear_valid; lo_next = 2'd2; end
      S_RELU: begin cur_valid = relu_valid;   lo_next = 2'd3; end
      default: ;
    endcase
  end

  wire in_stage = (st == S_CMVN) || (st == S_LIN) || (st == S_RELU);
  wire accept   = (st == S_IDLE) && start && !abort;

`ifdef KWS_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd;
  logic            err_q;

  // Any non-stage state or counted valid rearms the watchdog, covering every stage entry.
  always_ff @(posedge clk) begin
    if (!rst_n || !in_stage || cur_valid) wd <= '0;
    else if (wd != WD_LAST)               wd <= wd + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        err_q <= 1'b0;
    else if (accept)                   err_q <= 1'b0;
    else if (st == S_ERR && !abort)    err_q <= 1'b1;
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      nf_q      <= '0;
      mask_q    <= '0;
      frame_cnt <= '0;
      elem_cnt  <= '0;
    end else if (abort && st != S_IDLE) begin
      st <= S_IDLE;
    end else begin
      case (st)
        S_IDLE: if (accept) begin
          nf_q      <= num_frames;
          mask_q    <= stage_mask;
          frame_cnt <= '0;
          elem_cnt  <= '0;
          st <= (stage_mask == 3'b000 || num_frames == 8'd0) ? S_DONE
                                                             : first_from(stage_mask, 2'd0);
        end
        S_CMVN, S_LIN, S_RELU: begin
          if (cur_valid) begin
            if (elem_cnt == ELEM_LAST) begin
              elem_cnt <= '0;
              st       <= first_from(mask_q, lo_next);
            end else begin
              elem_cnt <= elem_cnt + 8'd1;
            end
          end
`ifdef KWS_SCHED_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            st <= S_ERR;
          end
`endif
        end
        S_NEXT: begin
          if (frame_cnt == nf_q - 8'd1) begin
            st <= S_DONE;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
            st        <= first_from(mask_q, 2'd0);
          end
        end
        S_DONE:  st <= S_IDLE;
        S_ERR:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign cmvn_en   = (st == S_CMVN);
  assign linear_en = (st == S_LIN);
  assign relu_en   = (st == S_RELU);
  assign busy      = (st != S_IDLE);
  assign done      = (st == S_DONE);
  assign state     = st;

endmodule

// File: tb/tb_kws_layer_sched.sv
// tb/tb_kws_layer_sched.sv - directed table and sequence bench for kws_layer_sched
// Expects KWS_SCHED_TIMEOUT_EN to be defined or not consistently with the RTL build.
module tb_kws_layer_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] num_frames;
  logic [2:0] stage_mask;
  logic       cmvn_valid, linear_valid, relu_valid;
  logic       cmvn_en, linear_en, relu_en;
  logic       busy, done, err_timeout;
  logic [7:0] frame_cnt, elem_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  kws_layer_sched #(.FRAME_LEN(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_frames(num_frames), .stage_mask(stage_mask),
    .cmvn_valid(cmvn_valid), .linear_valid(linear_valid), .relu_valid(relu_valid),
    .cmvn_en(cmvn_en), .linear_en(linear_en), .relu_en(relu_en),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt), .elem_cnt(elem_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] nf;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] m, input logic [7:0] nf);
    stage_mask = m;
    num_frames = nf;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int ens();
    return {29'd0, relu_en, linear_en, cmvn_en};
  endfunction

  task automatic feed(input int stage, input int first, input int n, input bit stray);
    logic [2:0] v;
    for (int i = 0; i < n; i++) begin
      chk("feed_en", ens(), 1 << stage);
      chk("feed_elem", elem_cnt, first + i);
      v = stray ? 3'b111 : 3'(1 << stage);
      {relu_valid, linear_valid, cmvn_valid} = v;
      tick();
    end
    {relu_valid, linear_valid, cmvn_valid} = 3'b000;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_state"}, state, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_en"}, ens(), 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_frames = '0; stage_mask = '0;
    cmvn_valid = 1'b0; linear_valid = 1'b0; relu_valid = 1'b0;

    tbl[0] = '{3'b000, 8'd5,   3'd5};
    tbl[1] = '{3'b001, 8'd1,   3'd1};
    tbl[2] = '{3'b010, 8'd3,   3'd2};
    tbl[3] = '{3'b100, 8'd1,   3'd3};
    tbl[4] = '{3'b110, 8'd1,   3'd2};
    tbl[5] = '{3'b101, 8'd2,   3'd1};
    tbl[6] = '{3'b111, 8'd0,   3'd5};
    tbl[7] = '{3'b011, 8'd255, 3'd1};

    tick(); tick();
    chk_idle("reset");
    chk("reset_err", err_timeout, 0);
    chk("reset_frame", frame_cnt, 0);
    chk("reset_elem", elem_cnt, 0);
    rst_n = 1'b1;
    tick();

    // start response per mask/frame count, then abort back to idle
    for (int k = 0; k < 8; k++) begin
      do_start(tbl[k].mask, tbl[k].nf);
      chk($sformatf("tbl%0d_state", k), state, tbl[k].st);
      chk($sformatf("tbl%0d_busy", k), busy, 1);
      chk($sformatf("tbl%0d_done", k), done, (tbl[k].st == 3'd5) ? 1 : 0);
      chk($sformatf("tbl%0d_en", k), ens(),
          (tbl[k].st >= 3'd1 && tbl[k].st <= 3'd3) ? (1 << (tbl[k].st - 1)) : 0);
      chk($sformatf("tbl%0d_frame", k), frame_cnt, 0);
      if (tbl[k].st == 3'd5) begin
        tick();
      end else begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      chk_idle($sformatf("tbl%0d_end", k));
    end

    // basic run: all stages, two frames
    do_start(3'b111, 8'd2);
    for (int f = 0; f < 2; f++) begin
      feed(0, 0, 4, 1'b0);
      feed(1, 0, 4, 1'b0);
      feed(2, 0, 4, 1'b0);
      chk("basic_next_state", state, 4);
      chk("basic_next_en", ens(), 0);
      chk("basic_next_frame", frame_cnt, f);
      tick();
      if (f == 0) begin
        chk("basic_f1_en", ens(), 1);
        chk("basic_f1_frame", frame_cnt, 1);
      end
    end
    chk("basic_done", done, 1);
    chk("basic_frame_final", frame_cnt, 1);
    tick();
    chk("basic_busy_after", busy, 0);
    chk("basic_done_after", done, 0);

    // sparse mask with stray valids from the other stages
    do_start(3'b101, 8'd1);
    feed(0, 0, 4, 1'b1);
    feed(2, 0, 4, 1'b1);
    chk("sparse_next", state, 4);
    tick();
    chk("sparse_done", done, 1);
    tick();

    // abort in LIN after two valids, then a clean rerun
    do_start(3'b111, 8'd1);
    feed(0, 0, 4, 1'b0);
    feed(1, 0, 2, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_lin");
    tick();
    chk("abort_no_done", done, 0);
    do_start(3'b011, 8'd1);
    chk("rerun_frame", frame_cnt, 0);
    chk("rerun_elem", elem_cnt, 0);
    feed(0, 0, 4, 1'b0);
    feed(1, 0, 4, 1'b0);
    tick();
    chk("rerun_done", done, 1);
    tick();

    // abort coinciding with the final valid
    do_start(3'b001, 8'd1);
    feed(0, 0, 3, 1'b0);
    cmvn_valid = 1'b1;
    abort = 1'b1;
    tick();
    cmvn_valid = 1'b0;
    abort = 1'b0;
    chk_idle("abort_final");
    tick();
    chk("abort_final_nodone", done, 0);

    // start and abort together in IDLE: start dropped
    stage_mask = 3'b111; num_frames = 8'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort");

`ifdef KWS_SCHED_TIMEOUT_EN
    do_start(3'b001, 8'd1);
    for (int i = 0; i < 10; i++) begin
      chk("to_no_done", done, 0);
      tick();
    end
    chk("to_err_state", state, 6);
    chk("to_err_flag_pre", err_timeout, 0);
    tick();
    chk("to_err_flag", err_timeout, 1);
    chk("to_idle", state, 0);
    chk("to_done", done, 0);
    tick();
    chk("to_sticky", err_timeout, 1);
    do_start(3'b000, 8'd1);
    chk("to_cleared", err_timeout, 0);
    tick();
`else
    do_start(3'b001, 8'd1);
    for (int i = 0; i < 40; i++) tick();
    chk("nowd_cmvn_en", cmvn_en, 1);
    chk("nowd_state", state, 1);
    chk("nowd_err", err_timeout, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("nowd_abort");
`endif

    // start while busy is ignored; reset mid-RELU
    do_start(3'b111, 8'd1);
    feed(0, 0, 2, 1'b0);
    stage_mask = 3'b010; num_frames = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_state", state, 1);
    chk("busy_start_elem", elem_cnt, 2);
    feed(0, 2, 2, 1'b0);
    feed(1, 0, 4, 1'b0);
    feed(2, 0, 2, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_idle("rst_mid");
    chk("rst_mid_err", err_timeout, 0);
    chk("rst_mid_frame", frame_cnt, 0);
    chk("rst_mid_elem", elem_cnt, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
